imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake. It extracts and sign-extends the immediate for every RV32I/RV64I format (I, S, B, U, J) to XLEN bits, and reports the format. A 2-entry elastic buffer (output register plus skid register) lets decode stall without dropping instructions. An opaque tag travels alongside each instruction so that downstream logic can re-associate the immediate with its PC or ROB slot.

Parameters:
XLEN, 32, result width; legal values 32 or 64, anything else is an elaboration error.
TAG_W, 5, width of the sideband tag carried with each instruction; minimum 1.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous flush; empties the buffer
in_valid  in  1  upstream has an instruction
in_ready  out  1  block can accept an instruction this cycle
in_instr  in  32  raw instruction word
in_tag  in  TAG_W  sideband tag
out_valid  out  1  out_* fields hold a valid result
out_ready  in  1  downstream accepts the result
out_imm  out  XLEN  sign-extended immediate
out_fmt  out  3  format code (FMT_* constants)
out_has_imm  out  1  1 when out_fmt != FMT_NONE
out_tag  out  TAG_W  tag of the instruction being presented

Behaviour:
- Reset is asynchronous, active-high.
  - Reset drives out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_fmt=FMT_NONE, out_has_imm=0, out_tag=0.
  - Reset mid-transfer drops every held entry.
- Decode (combinational, applied on the input side) uses opcode=in_instr[6:0]:
  - FMT_I for 0000011, 0010011, 0011011, 1100111, 1110011: imm = sext(instr[31:20]).
  - FMT_S for 0100011: imm = sext({instr[31:25], instr[11:7]}).
  - FMT_B for 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - FMT_U for 0110111, 0010111: imm = sext({instr[31:12], 12'b0}). At XLEN=64, bit 31 is replicated into bits 63:32.
  - FMT_J for 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode gives FMT_NONE with imm=0. The output is never X.
  - OP-IMM shifts are not special-cased: the raw I-immediate is emitted.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - in_ready is a register: in_ready = !skid_valid.
  - Latency is 1 cycle. An instruction accepted at edge N appears on out_* after edge N, provided the output register was empty or drained at N.
  - Throughput is 1 per cycle while out_ready=1.
- Buffer update on each edge:
  - If the output register is empty, or is being drained:
    - If skid_valid: move the skid entry into the output register. If an input transfer also occurs, write it into the skid; otherwise clear skid_valid.
    - Else, if an input transfer occurs: load the decoded input into the output register.
    - Else: clear out_valid.
  - If the output is held (out_valid && !out_ready) and an input transfer occurs, the entry goes into the skid. This is only possible while the skid is empty.
- Ordering is strictly FIFO. There is no combinational path from out_ready to in_ready.
- out_* remain stable while out_valid && !out_ready.
- flush has priority over all transfers in the same cycle:
  - Next state is out_valid=0, skid_valid=0, in_ready=1.
  - An input offered during the flush cycle is discarded.
- With the buffer full (out_valid=1, skid_valid=1) and out_ready=0, in_ready=0 and the state is held indefinitely.

Decomposition:
- Package imm_gen_pkg holds:
  - format codes FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5;
  - opcode constants OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
- Sub-module imm_decode (combinational, parameter XLEN): in_instr -> {imm, fmt}.
  - Instantiated once, on the input side.
  - Reusable elsewhere in the core without the buffer.

Test Plan:
1. XLEN=32, instr 0xFF813283 (ld x5,-8(x2)) with out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFF8, out_fmt=FMT_I, out_has_imm=1, tag echoed.
2. Back-to-back stream: 0x00613823 (sd, imm=0x10), 0xFE000EE3 (beq, -4), 0xFFFFF06F (jal, -2) -> consecutive results 0x00000010/S, 0xFFFFFFFC/B, 0xFFFFFFFE/J, one per cycle.
3. XLEN=64: 0x123450B7 -> 0x0000000012345000/U; 0x800000B7 -> 0xFFFFFFFF80000000/U; R-type 0x002081B3 -> imm=0, FMT_NONE, out_has_imm=0.
4. Backpressure: out_ready=0, offer tags 1,2,3 -> tag1 held on out_*, tag2 in skid, in_ready=0 while tag3 is offered. Raise out_ready -> tags 1,2,3 emerge in order with no loss or duplication.
5. Full buffer plus flush asserted together with in_valid -> next cycle out_valid=0, in_ready=1, the offered instruction never appears.
6. Assert reset asynchronously between edges with the buffer full -> outputs go to their reset values immediately. After reset release, the first accepted instruction emerges after 1 cycle.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared constants for the immediate generator.
//   fmt_e    - format codes reported alongside each decoded immediate
//   OPC_*    - RV32I/RV64I major opcodes (instr[6:0]) that carry an immediate
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extractor for RV32I/RV64I.
//   instr_i - raw 32-bit instruction word
//   imm_o   - immediate, sign-extended to XLEN bits (0 for formats without one)
//   fmt_o   - format code (fmt_e value)
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  logic [31:0] imm32;
  fmt_e        fmt;

  // Every format takes its sign from instr[31], so build a 32-bit value
  // first and sign-extend once to XLEN.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_NONE;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr_i[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));
  assign fmt_o = fmt;

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator with a 2-entry elastic
// buffer (output register + skid register) on a valid/ready handshake.
//   clock, reset (async, active-high), flush (sync, empties the buffer)
//   in_valid/in_ready/in_instr/in_tag       - upstream instruction channel
//   out_valid/out_ready                     - downstream handshake
//   out_imm/out_fmt/out_has_imm/out_tag     - decoded result and its tag
// in_ready is registered (= !skid_valid); no combinational out_ready->in_ready path.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_has_imm,
  output logic [TAG_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_gen_pipe: TAG_W must be at least 1");
  end

  logic [XLEN-1:0]  dec_imm;
  logic [2:0]       dec_fmt;

  logic             out_valid_q,  out_valid_d;
  logic [XLEN-1:0]  out_imm_q,    out_imm_d;
  logic [2:0]       out_fmt_q,    out_fmt_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_fmt_q,   skid_fmt_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             in_ready_q,   in_ready_d;

  logic in_xfer;
  logic out_free;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr_i (in_instr),
    .imm_o   (dec_imm),
    .fmt_o   (dec_fmt)
  );

  assign in_xfer  = in_valid && in_ready_q;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        // Oldest entry lives in the skid; promote it before taking new input.
        out_valid_d = 1'b1;
        out_imm_d   = skid_imm_q;
        out_fmt_d   = skid_fmt_q;
        out_tag_d   = skid_tag_q;
        if (in_xfer) begin
          skid_imm_d = dec_imm;
          skid_fmt_d = dec_fmt;
          skid_tag_d = in_tag;
        end else begin
          skid_valid_d = 1'b0;
        end
      end else if (in_xfer) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm;
        out_fmt_d   = dec_fmt;
        out_tag_d   = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_tag_d   = in_tag;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= FMT_NONE;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= FMT_NONE;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_tag     = out_tag_q;
  assign out_has_imm = (out_fmt_q != FMT_NONE);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance
// share the same stimulus; expected results come from a field-level reference
// decoder and a queue model of the 2-entry buffer.
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_instr = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_ready = 1'b1;

  logic             in_ready32, out_valid32, has32;
  logic [31:0]      imm32;
  logic [2:0]       fmt32;
  logic [TAG_W-1:0] tag32;
  logic             in_ready64, out_valid64, has64;
  logic [63:0]      imm64;
  logic [2:0]       fmt64;
  logic [TAG_W-1:0] tag64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(imm32),
    .out_fmt(fmt32), .out_has_imm(has32), .out_tag(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(imm64),
    .out_fmt(fmt64), .out_has_imm(has64), .out_tag(tag64)
  );

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    logic [63:0]      imm;
    logic [2:0]       fmt;   // 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
  } vec_t;

  typedef struct {
    logic [63:0]      imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } exp_t;

  vec_t vecs[8];
  exp_t q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input bit ev, input logic [63:0] eimm,
                         input logic [2:0] efmt, input logic [TAG_W-1:0] etag, input bit erdy);
    chk({nm, " valid32"}, 64'(out_valid32), 64'(ev));
    chk({nm, " valid64"}, 64'(out_valid64), 64'(ev));
    chk({nm, " ready32"}, 64'(in_ready32), 64'(erdy));
    chk({nm, " ready64"}, 64'(in_ready64), 64'(erdy));
    if (ev) begin
      chk({nm, " imm32"}, 64'(imm32), 64'(eimm[31:0]));
      chk({nm, " imm64"}, imm64, eimm);
      chk({nm, " fmt32"}, 64'(fmt32), 64'(efmt));
      chk({nm, " fmt64"}, 64'(fmt64), 64'(efmt));
      chk({nm, " has32"}, 64'(has32), 64'(efmt != 3'd0));
      chk({nm, " has64"}, 64'(has64), 64'(efmt != 3'd0));
      chk({nm, " tag32"}, 64'(tag32), 64'(etag));
      chk({nm, " tag64"}, 64'(tag64), 64'(etag));
    end
  endtask

  task automatic chk_reset(input string nm);
    chk_out(nm, 1'b0, '0, 3'd0, '0, 1'b1);
    chk({nm, " rimm32"}, 64'(imm32), 64'd0);
    chk({nm, " rimm64"}, imm64, 64'd0);
    chk({nm, " rfmt"}, 64'({fmt32, fmt64}), 64'd0);
    chk({nm, " rhas"}, 64'({has32, has64}), 64'd0);
    chk({nm, " rtag"}, 64'({tag32, tag64}), 64'd0);
  endtask

  // Reference decode built straight from the ISA field layouts.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [TAG_W-1:0] tag);
    exp_t e;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    longint v;
    e.tag = tag;
    v = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin e.fmt = 3'd1; i12 = ins[31:20]; v = i12; end
      7'h23: begin e.fmt = 3'd2; i12 = {ins[31:25], ins[11:7]}; v = i12; end
      7'h63: begin e.fmt = 3'd3; b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; v = b13; end
      7'h37, 7'h17: begin e.fmt = 3'd4; u32 = {ins[31:12], 12'h000}; v = u32; end
      7'h6F: begin e.fmt = 3'd5; j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; v = j21; end
      default: begin e.fmt = 3'd0; v = 0; end
    endcase
    e.imm = v;
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs[11];
    logic [31:0] ins;
    int unsigned k;
    opcs = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    ins = $urandom;
    k = $urandom_range(0, 11);
    if (k < 11) ins[6:0] = opcs[k];
    return ins;
  endfunction

  task automatic drive(input bit v, input logic [31:0] ins, input logic [TAG_W-1:0] t);
    in_valid = v;
    in_instr = ins;
    in_tag   = t;
  endtask

  initial begin
    exp_t e;
    bit acc_in, acc_out;

    vecs[0] = '{32'hFF813283, 5'd1,  64'hFFFFFFFFFFFFFFF8, 3'd1};  // ld x5,-8(x2)
    vecs[1] = '{32'h00613823, 5'd2,  64'h0000000000000010, 3'd2};  // sd
    vecs[2] = '{32'hFE000EE3, 5'd3,  64'hFFFFFFFFFFFFFFFC, 3'd3};  // beq -4
    vecs[3] = '{32'hFFFFF06F, 5'd4,  64'hFFFFFFFFFFFFFFFE, 3'd5};  // jal -2
    vecs[4] = '{32'h123450B7, 5'd5,  64'h0000000012345000, 3'd4};  // lui
    vecs[5] = '{32'h800000B7, 5'd6,  64'hFFFFFFFF80000000, 3'd4};  // lui, negative
    vecs[6] = '{32'h002081B3, 5'd7,  64'h0000000000000000, 3'd0};  // add (R-type)
    vecs[7] = '{32'h7FF00013, 5'd31, 64'h00000000000007FF, 3'd1};  // addi max

    // Reset state
    #12;
    chk_reset("reset");
    @(negedge clock);
    reset = 1'b0;

    // Table: back-to-back stream, one result per cycle with out_ready=1
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].tag);
      @(posedge clock);
      #1;
      chk_out($sformatf("vec%0d", i), 1'b1, vecs[i].imm, vecs[i].fmt, vecs[i].tag, 1'b1);
      @(negedge clock);
    end
    drive(1'b0, '0, '0);
    @(posedge clock); #1;
    chk_out("drain", 1'b0, '0, 3'd0, '0, 1'b1);

    // Backpressure: tags 1,2,3 with out_ready=0, then release
    @(negedge clock);
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, 5'd1);
    @(posedge clock); #1;
    chk_out("bp t1", 1'b1, vecs[0].imm, vecs[0].fmt, 5'd1, 1'b1);
    @(negedge clock);
    drive(1'b1, vecs[1].instr, 5'd2);
    @(posedge clock); #1;
    chk_out("bp skid", 1'b1, vecs[0].imm, vecs[0].fmt, 5'd1, 1'b0);
    @(negedge clock);
    drive(1'b1, vecs[2].instr, 5'd3);
    repeat (3) begin
      @(posedge clock); #1;
      chk_out("bp full", 1'b1, vecs[0].imm, vecs[0].fmt, 5'd1, 1'b0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk_out("bp t2", 1'b1, vecs[1].imm, vecs[1].fmt, 5'd2, 1'b1);
    @(posedge clock); #1;
    chk_out("bp t3", 1'b1, vecs[2].imm, vecs[2].fmt, 5'd3, 1'b1);
    @(negedge clock);
    drive(1'b0, '0, '0);
    @(posedge clock); #1;
    chk_out("bp empty", 1'b0, '0, 3'd0, '0, 1'b1);

    // Full buffer + flush + offered input
    @(negedge clock);
    out_ready = 1'b0;
    drive(1'b1, vecs[3].instr, 5'd9);
    @(negedge clock);
    drive(1'b1, vecs[4].instr, 5'd10);
    @(negedge clock);
    flush = 1'b1;
    drive(1'b1, vecs[5].instr, 5'd11);
    @(posedge clock); #1;
    chk_out("flush", 1'b0, '0, 3'd0, '0, 1'b1);
    @(negedge clock);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0);
    repeat (2) begin
      @(posedge clock); #1;
      chk_out("post flush", 1'b0, '0, 3'd0, '0, 1'b1);
    end

    // Async reset between edges with the buffer full
    @(negedge clock);
    out_ready = 1'b0;
    drive(1'b1, vecs[0].instr, 5'd12);
    @(negedge clock);
    drive(1'b1, vecs[1].instr, 5'd13);
    @(negedge clock);
    drive(1'b0, '0, '0);
    #2 reset = 1'b1;
    #1 chk_reset("async reset");
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, vecs[2].instr, 5'd14);
    @(posedge clock); #1;
    chk_out("after reset", 1'b1, vecs[2].imm, vecs[2].fmt, 5'd14, 1'b1);
    @(negedge clock);
    drive(1'b0, '0, '0);
    @(posedge clock); #1;
    chk_out("after reset empty", 1'b0, '0, 3'd0, '0, 1'b1);

    // Randomized traffic against the queue model
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = rand_instr();
      in_tag    = TAG_W'($urandom);
      acc_in  = in_valid && (q.size() < 2);
      acc_out = (q.size() > 0) && out_ready;
      e = ref_dec(in_instr, in_tag);
      @(posedge clock);
      if (flush) begin
        q.delete();
      end else begin
        if (acc_out) void'(q.pop_front());
        if (acc_in) q.push_back(e);
      end
      #1;
      if (q.size() > 0) chk_out("rnd", 1'b1, q[0].imm, q[0].fmt, q[0].tag, q.size() < 2);
      else              chk_out("rnd", 1'b0, '0, 3'd0, '0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
